// File: rtl/shift_sub_div_if.sv
// Operand/result bundle for shift_sub_div: the requester drives the start
// strobe and operands, the divider returns the result, flags and status.
interface shift_sub_div_if;
    logic        parser_done;
    logic [15:0] src1;
    logic [15:0] src2;
    logic [31:0] calc_res;
    logic        div_zero;
    logic        busy;
    logic        div_done;

    modport master (
        output parser_done, src1, src2,
        input  calc_res, div_zero, busy, div_done
    );

    modport slave (
        input  parser_done, src1, src2,
        output calc_res, div_zero, busy, div_done
    );
endinterface

// File: rtl/shift_sub_div.sv
// 16/16 restoring shift-subtract divider, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement operands (truncating division).
module shift_sub_div (
    input  logic                  clk,
    input  logic                  n_rst,
    shift_sub_div_if.slave        bus,
    output logic [1:0]            dbg_state
);
    // Handshake: parser_done is a single-cycle start strobe with src1/src2 valid
    // in the same cycle; it is honoured only in IDLE and ignored otherwise.
    // div_done pulses for one cycle in STOP, when calc_res/div_zero are fresh;
    // they then hold until the next result load. busy is high throughout CALC.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q;
    logic [15:0] dvd_q;   // dividend, shifted out MSB-first; quotient shifts in
    logic [15:0] dvs_q;
    logic [15:0] rem_q;

    logic [16:0] trial;
    logic [16:0] diff;
    logic        take;
    logic [15:0] rem_nxt;
    logic [15:0] dvd_nxt;
    logic [15:0] cap_dvd;
    logic [15:0] cap_dvs;
    logic [15:0] res_q;
    logic [15:0] res_r;

    assign dbg_state = state_q;

    // One restoring iteration; diff[16] set means the trial was below the divisor.
    assign trial   = {rem_q, dvd_q[15]};
    assign diff    = trial - {1'b0, dvs_q};
    assign take    = ~diff[16];
    assign rem_nxt = take ? diff[15:0] : trial[15:0];
    assign dvd_nxt = {dvd_q[14:0], take};

`ifdef DIV_SIGNED_EN
    logic q_neg_q;
    logic r_neg_q;

    // Magnitude of -32768 wraps to 16'h8000, which is correct as unsigned.
    function automatic logic [15:0] mag(input logic [15:0] v);
        return v[15] ? (~v + 16'd1) : v;
    endfunction

    assign cap_dvd = mag(bus.src1);
    assign cap_dvs = mag(bus.src2);
    assign res_q   = q_neg_q ? (~dvd_nxt + 16'd1) : dvd_nxt;
    assign res_r   = r_neg_q ? (~rem_nxt + 16'd1) : rem_nxt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else if (state_q == IDLE && bus.parser_done) begin
            q_neg_q <= bus.src1[15] ^ bus.src2[15];
            r_neg_q <= bus.src1[15];
        end
    end
`else
    assign cap_dvd = bus.src1;
    assign cap_dvs = bus.src2;
    assign res_q   = dvd_nxt;
    assign res_r   = rem_nxt;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        bus.busy     = 1'b0;
        bus.div_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.parser_done)
                    state_d = (bus.src2 == 16'd0) ? STOP : CALC;
            end
            CALC: begin
                bus.busy = 1'b1;
                if (cnt_q == 4'd15) state_d = STOP;
            end
            STOP: begin
                bus.div_done = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q        <= 4'd0;
            dvd_q        <= 16'd0;
            dvs_q        <= 16'd0;
            rem_q        <= 16'd0;
            bus.calc_res <= 32'd0;
            bus.div_zero <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.parser_done) begin
                        cnt_q <= 4'd0;
                        rem_q <= 16'd0;
                        dvd_q <= cap_dvd;
                        dvs_q <= cap_dvs;
                        if (bus.src2 == 16'd0) begin
                            bus.calc_res <= {bus.src1, 16'hFFFF};
                            bus.div_zero <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q + 4'd1;
                    dvd_q <= dvd_nxt;
                    rem_q <= rem_nxt;
                    if (cnt_q == 4'd15) begin
                        bus.calc_res <= {res_r, res_q};
                        bus.div_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_sub_div.sv
// Directed bench for shift_sub_div: latency, results, divide-by-zero,
// ignored restarts and reset abort, against hand-computed values.
module tb_shift_sub_div;
    logic       clk = 1'b0;
    logic       n_rst;
    logic [1:0] dbg_state;
    int         n_checks = 0;
    int         n_fail   = 0;

    shift_sub_div_if dif();

    shift_sub_div dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .bus       (dif),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Pulses parser_done for one cycle, then counts cycles until div_done.
    // poke_at re-strobes with other operands; rst_at asserts reset mid-run.
    task automatic run_div(input logic [15:0] a, input logic [15:0] b,
                           input int poke_at, input int rst_at,
                           output int lat, output int bcnt);
        @(negedge clk);
        dif.src1 = a;
        dif.src2 = b;
        dif.parser_done = 1'b1;
        @(posedge clk);
        #1;
        dif.parser_done = 1'b0;
        lat  = 0;
        bcnt = 0;
        while (!dif.div_done && lat < 40) begin
            if (lat == rst_at) begin
                n_rst = 1'b0;
                return;
            end
            if (lat == poke_at) begin
                dif.parser_done = 1'b1;
                dif.src1 = 16'd8;
                dif.src2 = 16'd2;
            end else if (lat == poke_at + 1) begin
                dif.parser_done = 1'b0;
            end
            bcnt += int'(dif.busy);
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic div_case(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic [31:0] exp_res, input logic exp_dz, input int poke_at);
        int lat, bcnt;
        logic [31:0] exp_lat;
        exp_lat = (b == 16'd0) ? 32'd0 : 32'd16;
        run_div(a, b, poke_at, -1, lat, bcnt);
        check({tag, "_lat"},  32'(lat),  exp_lat);
        check({tag, "_busy"}, 32'(bcnt), exp_lat);
        check({tag, "_res"},  dif.calc_res, exp_res);
        check({tag, "_dz"},   32'(dif.div_zero), 32'(exp_dz));
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, 32'(dif.div_done), 32'd0);
        check({tag, "_hold"},  dif.calc_res, exp_res);
    endtask

    initial begin
        int lat, bcnt, seen;
        n_rst = 1'b0;
        dif.parser_done = 1'b0;
        dif.src1 = 16'd0;
        dif.src2 = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_res",   dif.calc_res, 32'd0);
        check("rst_dz",    32'(dif.div_zero), 32'd0);
        check("rst_busy",  32'(dif.busy), 32'd0);
        check("rst_done",  32'(dif.div_done), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;

        div_case("d100_7",   16'd100,   16'd7,    32'h0002_000E, 1'b0, -1);
        div_case("dffff_1",  16'hFFFF,  16'd1,    32'h0000_FFFF, 1'b0, -1);
        div_case("d5_9",     16'd5,     16'd9,    32'h0005_0000, 1'b0, -1);
        div_case("dz_1234",  16'h1234,  16'd0,    32'h1234_FFFF, 1'b1, -1);
        div_case("d20_5",    16'd20,    16'd5,    32'h0000_0004, 1'b0, -1);
        div_case("d1000_3",  16'd1000,  16'd3,    32'h0001_014D, 1'b0, 5);
        div_case("dffff_ff", 16'hFFFF,  16'hFFFF, 32'h0000_0001, 1'b0, -1);
        div_case("d0_5",     16'd0,     16'd5,    32'h0000_0000, 1'b0, -1);
`ifdef DIV_SIGNED_EN
        div_case("s_m7_2",   16'hFFF9,  16'd2,    32'hFFFF_FFFD, 1'b0, -1);
        div_case("s_7_m2",   16'd7,     16'hFFFE, 32'h0001_FFFD, 1'b0, -1);
        div_case("s_min_m1", 16'h8000,  16'hFFFF, 32'h0000_8000, 1'b0, -1);
`else
        div_case("d8000_ff", 16'h8000,  16'h00FF, 32'h0080_0080, 1'b0, -1);
`endif

        // Leave nonzero outputs and div_zero set so the reset abort is visible.
        div_case("dz_00ab",  16'h00AB,  16'd0,    32'h00AB_FFFF, 1'b1, -1);
        run_div(16'd1000, 16'd3, -1, 8, lat, bcnt);
        check("abort_lat", 32'(lat), 32'd8);
        #1;
        check("abort_res",   dif.calc_res, 32'd0);
        check("abort_dz",    32'(dif.div_zero), 32'd0);
        check("abort_busy",  32'(dif.busy), 32'd0);
        check("abort_state", 32'(dbg_state), 32'd0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (dif.div_done) seen++;
        end
        check("abort_no_done", 32'(seen), 32'd0);

        div_case("fresh_100_7", 16'd100, 16'd7, 32'h0002_000E, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/shift_sub_div.md
SHIFT_SUB_DIV -- requirements
Module: shift_sub_div

Interface
REQ-001 SHALL have: clk  input  1  rising-edge clock.
REQ-002 SHALL have: n_rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have: parser_done  input  1  start strobe; operands valid in the same cycle.
REQ-004 SHALL have: src1  input  16  dividend.
REQ-005 SHALL have: src2  input  16  divisor.
REQ-006 SHALL have: calc_res  output  32  registered result, {remainder[15:0], quotient[15:0]}.
REQ-007 SHALL have: div_zero  output  1  registered flag, set when the last division had src2 == 0.
REQ-008 SHALL have: busy  output  1  high while in state CALC.
REQ-009 SHALL have: div_done  output  1  one-cycle completion pulse.

Function
REQ-010 SHALL implement the FSM states IDLE, CALC and STOP; unused encodings SHALL return to IDLE.
REQ-011 IDLE: on parser_done=1, SHALL capture src1/src2 and go to CALC if src2 != 0, or to STOP if src2 == 0.
REQ-012 CALC: SHALL perform one restoring shift-subtract iteration per clock, MSB first, for exactly 16 cycles, counted by a 4-bit counter 0..15.
REQ-013 Each iteration SHALL set the partial remainder to {rem[15:0], dividend MSB}, a 17-bit value; if it is >= divisor, the divisor SHALL be subtracted and quotient bit 1 shifted in, otherwise quotient bit 0 shifted in.
REQ-014 At counter==15, SHALL load calc_res and go to STOP; STOP SHALL unconditionally go to IDLE.
REQ-015 div_done SHALL be high only in STOP.
REQ-016 Latency: parser_done sampled at edge E0, div_done high in the cycle after edge E16; divide-by-zero case has div_done high in the cycle after E0.
REQ-017 Divide-by-zero SHALL give calc_res = {src1, 16'hFFFF} and div_zero=1.
REQ-018 Any completed nonzero-divisor division SHALL clear div_zero.
REQ-019 calc_res and div_zero SHALL hold their values from div_done until the next result load.
REQ-020 parser_done in CALC or STOP SHALL be ignored (no restart, no operand recapture).
REQ-021 Operand changes after capture SHALL NOT affect the result.
REQ-022 Unsigned results SHALL satisfy quotient*divisor + remainder == dividend and remainder < divisor.

Reset
REQ-023 n_rst low SHALL immediately force: state IDLE, counter 0, internal operand/remainder registers 0, calc_res 0, div_zero 0, busy 0, div_done 0.
REQ-024 Reset during CALC SHALL abort the operation with no div_done pulse.
REQ-025 After release, the first parser_done SHALL start a fresh division.

Configuration
REQ-026 Macro DIV_SIGNED_EN defined: src1/src2 SHALL be two's complement.
- Magnitudes taken at capture; iteration as REQ-013.
- Quotient negated if operand signs differ; remainder takes the dividend's sign (truncation toward zero).
- Sign correction SHALL be applied in the same edge as the result load, so latency is unchanged.
- -32768 / -1 SHALL give quotient 16'h8000, remainder 0.
REQ-027 Macro DIV_SIGNED_EN undefined: all operands and results SHALL be unsigned and no sign logic SHALL be synthesized.
REQ-028 Divide-by-zero behaviour (REQ-017) SHALL be identical in both builds.

Verification
REQ-029 src1=100, src2=7, parser_done pulse -> busy for 16 cycles, div_done in the cycle after E16, calc_res=32'h0002_000E, div_zero=0.
REQ-030 src1=16'hFFFF, src2=1 -> calc_res=32'h0000_FFFF; src1=5, src2=9 -> calc_res=32'h0005_0000.
REQ-031 src1=16'h1234, src2=0 -> div_done in the cycle after E0, calc_res=32'h1234_FFFF, div_zero=1; the next 20/5 division -> div_zero=0, calc_res=32'h0000_0004.
REQ-032 Start 1000/3, then pulse parser_done with src1=8, src2=2 at counter 5 -> ignored, calc_res=32'h0001_014D; n_rst low at counter 8 of a later run -> outputs 0, no div_done.
REQ-033 With DIV_SIGNED_EN: -7/2 -> calc_res=32'hFFFF_FFFD; 7/-2 -> 32'h0001_FFFD; -32768/-1 -> 32'h0000_8000.
